// File: rtl/sel_mux_reg_if.sv
// Bus bundle for sel_mux_reg: N parallel input words, select and load enable in;
// combinational word, registered word and out-of-range flag out.
// No handshake; the master drives inputs, the slave (the mux) drives results.
interface sel_mux_reg_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] din [N];
  logic [SEL_W-1:0] sel;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             sel_err;

  modport master (
    output din, sel, en,
    input  y, y_q, sel_err
  );

  modport slave (
    input  din, sel, en,
    output y, y_q, sel_err
  );
endinterface

// File: rtl/sel_mux_reg.sv
// N-way WIDTH-bit word mux: y = din[sel] combinationally, zero when sel >= N.
// Latency: y 0 cycles, y_q / sel_err 1 cycle when en=1; both hold when en=0.
// No backpressure. Optional registered out-of-range flag under MUX_SEL_ERR_EN.
module sel_mux_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sel_mux_reg_if.slave   bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] y_c;

  // Compare-based select: never indexes din with an out-of-range sel.
  always_comb begin
    y_c = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        y_c = bus.din[i];
      end
    end
  end

  assign bus.y = y_c;

  // Registered copy of the selected word, loaded only when en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y_q <= '0;
    end else if (bus.en) begin
      bus.y_q <= y_c;
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic sel_hit;

  // A select is in range exactly when it matches one of the N word positions.
  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        sel_hit = 1'b1;
      end
    end
  end

  // Out-of-range flag sampled alongside y_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sel_err <= 1'b0;
    end else if (bus.en) begin
      bus.sel_err <= ~sel_hit;
    end
  end
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_sel_mux_reg.sv
// Directed bench for sel_mux_reg: a 4-way instance for the main datapath and a
// 3-way instance for out-of-range selects; expected sel_err follows MUX_SEL_ERR_EN.
module tb_sel_mux_reg;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sel_mux_reg_if #(.WIDTH(8), .N(4)) if4 ();
  sel_mux_reg_if #(.WIDTH(8), .N(3)) if3 ();

  sel_mux_reg #(.WIDTH(8), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  sel_mux_reg #(.WIDTH(8), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] c [4];
    logic [7:0] exp_y;
    logic [1:0] s;
    logic       exp_err;

`ifdef MUX_SEL_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    errors = 0;
    checks = 0;

    // Reset state
    rst_n  = 1'b0;
    if4.en  = 1'b0;
    if4.sel = 2'd0;
    if3.en  = 1'b0;
    if3.sel = 2'd0;
    for (int i = 0; i < 4; i++) if4.din[i] = 8'h00;
    if3.din[0] = 8'hA0;
    if3.din[1] = 8'hA1;
    if3.din[2] = 8'hA2;
    #1;
    chk("rst_y_q4", 32'(if4.y_q), 32'h0);
    chk("rst_err4", 32'(if4.sel_err), 32'h0);
    chk("rst_y_q3", 32'(if3.y_q), 32'h0);
    chk("rst_err3", 32'(if3.sel_err), 32'h0);
    #2;
    rst_n = 1'b1;

    // Free-running counters at 10/20/40/80, sel stepping every 160 and wrapping
    c[0] = 8'h00; c[1] = 8'h40; c[2] = 8'h80; c[3] = 8'hC0;
    for (int t = 0; t < 64; t++) begin
      c[0] = c[0] + 8'd1;
      if (t % 2 == 0) c[1] = c[1] + 8'd1;
      if (t % 4 == 0) c[2] = c[2] + 8'd1;
      if (t % 8 == 0) c[3] = c[3] + 8'd1;
      s = 2'((t / 16) % 4);
      for (int i = 0; i < 4; i++) if4.din[i] = c[i];
      if4.sel = s;
      exp_y = c[s];
      #1;
      chk("cnt_y", 32'(if4.y), 32'(exp_y));
      #9;
    end
    chk("cnt_hold_y_q", 32'(if4.y_q), 32'h0);

    // Load 0x33 through sel=2
    @(negedge clk);
    if4.din[0] = 8'h11; if4.din[1] = 8'h22; if4.din[2] = 8'h33; if4.din[3] = 8'h44;
    if4.sel = 2'd2;
    if4.en  = 1'b1;
    #1;
    chk("load_y", 32'(if4.y), 32'h33);
    @(posedge clk); #1;
    chk("load_y_q", 32'(if4.y_q), 32'h33);
    chk("load_err4", 32'(if4.sel_err), 32'h0);

    // Hold with en=0 over five edges
    @(negedge clk);
    if4.en  = 1'b0;
    if4.sel = 2'd0;
    #1;
    chk("hold_y", 32'(if4.y), 32'h11);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_y_q", 32'(if4.y_q), 32'h33);

    // Async reset pulse between edges
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_y_q", 32'(if4.y_q), 32'h0);
    chk("arst_err", 32'(if4.sel_err), 32'h0);
    chk("arst_y", 32'(if4.y), 32'h11);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_no_en", 32'(if4.y_q), 32'h0);
    @(negedge clk);
    if4.en = 1'b1;
    @(posedge clk); #1;
    chk("rel_first_load", 32'(if4.y_q), 32'h11);

    // Three-way instance: preload, then out-of-range select
    @(negedge clk);
    if3.sel = 2'd2;
    if3.en  = 1'b1;
    @(posedge clk); #1;
    chk("n3_preload", 32'(if3.y_q), 32'hA2);
    @(negedge clk);
    if3.sel = 2'd3;
    #1;
    chk("n3_oor_y", 32'(if3.y), 32'h0);
    @(posedge clk); #1;
    chk("n3_oor_y_q", 32'(if3.y_q), 32'h0);
    chk("n3_oor_err", 32'(if3.sel_err), 32'(exp_err));
    @(negedge clk);
    if3.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("n3_err_hold", 32'(if3.sel_err), 32'(exp_err));
    @(negedge clk);
    if3.sel = 2'd1;
    if3.en  = 1'b1;
    #1;
    chk("n3_in_y", 32'(if3.y), 32'hA1);
    @(posedge clk); #1;
    chk("n3_in_y_q", 32'(if3.y_q), 32'hA1);
    chk("n3_in_err", 32'(if3.sel_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
